collision_score: RTL and testbench

- Downstream consumer of the level generator's obstacle_pix and the duck sprite pixel stream.
- Counts per-frame pixel overlap between duck and obstacles, and turns it into hits, lives and game-over.
- Keeps a BCD run score and a BCD high score for the HUD/text renderer.
- Sits between the pixel generators and the VGA colour mux / top-level state machine.

---
 rtl/collision_score_if.sv | 29 ++
 rtl/collision_score.sv | 185 ++++++++++++++++++
 tb/tb_collision_score.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_score_if.sv
// Pixel-side bus between the sprite generators / game FSM and collision_score.
// The slave side is the collision block; the master side drives coordinates and pixels.
interface collision_score_if #(
  parameter int CIDXW = 3,
  parameter int CORDW = 10
);
  logic [3:0]       state;
  logic [CORDW-1:0] hc;
  logic [CORDW-1:0] vc;
  logic [CIDXW:0]   player_pix;
  logic [CIDXW:0]   obstacle_pix;
  logic             restart;
  logic             hit;
  logic             game_over;
  logic             flash;
  logic [2:0]       lives;
  logic [15:0]      score_bcd;
  logic [15:0]      hi_score_bcd;

  modport master (
    output state, hc, vc, player_pix, obstacle_pix, restart,
    input  hit, game_over, flash, lives, score_bcd, hi_score_bcd
  );

  modport slave (
    input  state, hc, vc, player_pix, obstacle_pix, restart,
    output hit, game_over, flash, lives, score_bcd, hi_score_bcd
  );
endinterface

// File: rtl/collision_score.sv
// Per-frame duck/obstacle overlap counter that turns overlaps into hits, lives and game-over,
// and keeps the BCD run score and high score for the HUD.
module collision_score #(
  parameter int CIDXW        = 3,
  parameter int CORDW        = 10,
  parameter int HIT_THRESH   = 4,
  parameter int LIVES        = 3,
  parameter int FLASH_FRAMES = 60,
  parameter int SCORE_DIV    = 6
) (
  input logic              CLK,
  input logic              RESET,
  collision_score_if.slave bus
);
  localparam int FCW  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam int DIVW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  localparam logic [CORDW-1:0] HC_MIN   = CORDW'(143);
  localparam logic [CORDW-1:0] HC_MAX   = CORDW'(784);
  localparam logic [CORDW-1:0] VC_MIN   = CORDW'(34);
  localparam logic [CORDW-1:0] VC_MAX   = CORDW'(516);
  localparam logic [CIDXW:0]   PIX_NONE = '0;

  typedef enum logic [1:0] {
    IDLE,
    PLAYING,
    HIT_FLASH,
    OVER
  } fsm_t;

  fsm_t             fsm;
  logic             match;
  logic             match_q;
  logic             tick;
  logic [CORDW-1:0] hc_d;
  logic [CORDW-1:0] vc_d;
  logic             in_window;
  logic             overlap_px;
  logic [7:0]       overlap;
  logic             running;
  logic [FCW-1:0]   flash_cnt;
  logic [DIVW-1:0]  div_cnt;
  logic             div_wrap;
  logic             score_step;
  logic [15:0]      score_next;
  logic             hit_r;
  logic             game_over_r;
  logic             flash_r;
  logic [2:0]       lives_r;
  logic [15:0]      score_r;
  logic [15:0]      hi_r;

  // BCD +1 with ripple carry between digits; 9999 is a hard ceiling.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign match      = (bus.hc == '0) && (bus.vc == '0);
  assign tick       = match && !match_q;
  assign running    = (bus.state >= 4'd5) && (bus.state <= 4'd10);
  assign in_window  = (hc_d >= HC_MIN) && (hc_d <= HC_MAX) &&
                      (vc_d >= VC_MIN) && (vc_d <= VC_MAX);
  assign overlap_px = in_window && (bus.player_pix != PIX_NONE) &&
                      (bus.obstacle_pix != PIX_NONE);
  assign score_step = tick && running && (fsm != OVER);
  assign div_wrap   = (div_cnt == DIVW'(SCORE_DIV - 1));

  // Pixels arrive one cycle after their coordinates, so the window test uses delayed hc/vc.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      match_q <= 1'b0;
      hc_d    <= '0;
      vc_d    <= '0;
      overlap <= '0;
    end else begin
      match_q <= match;
      hc_d    <= bus.hc;
      vc_d    <= bus.vc;
      if (tick) begin
        overlap <= '0;
      end else if (overlap_px && (overlap != 8'hFF)) begin
        overlap <= overlap + 8'd1;
      end
    end
  end

  always_comb begin
    score_next = score_r;
    if (score_step && div_wrap) begin
      score_next = bcd_inc(score_r);
    end
  end

  // Game FSM; the high score samples score_next so a same-tick increment is included.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fsm         <= IDLE;
      hit_r       <= 1'b0;
      game_over_r <= 1'b0;
      flash_r     <= 1'b0;
      lives_r     <= 3'(LIVES);
      score_r     <= '0;
      hi_r        <= '0;
      div_cnt     <= '0;
      flash_cnt   <= '0;
    end else begin
      hit_r <= 1'b0;
      if (score_step) begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIVW'(1);
        score_r <= score_next;
      end
      case (fsm)
        IDLE: begin
          flash_r     <= 1'b0;
          game_over_r <= 1'b0;
          lives_r     <= 3'(LIVES);
          if (tick && running) begin
            fsm <= PLAYING;
          end
        end
        PLAYING: begin
          if (tick && running && (overlap >= 8'(HIT_THRESH))) begin
            hit_r   <= 1'b1;
            lives_r <= lives_r - 3'd1;
            if (lives_r == 3'd1) begin
              fsm         <= OVER;
              game_over_r <= 1'b1;
              if (score_next > hi_r) begin
                hi_r <= score_next;
              end
            end else begin
              fsm       <= HIT_FLASH;
              flash_r   <= 1'b1;
              flash_cnt <= FCW'(FLASH_FRAMES);
            end
          end
        end
        HIT_FLASH: begin
          if (tick) begin
            if (flash_cnt <= FCW'(1)) begin
              fsm       <= PLAYING;
              flash_r   <= 1'b0;
              flash_cnt <= '0;
            end else begin
              flash_cnt <= flash_cnt - FCW'(1);
            end
          end
        end
        OVER: begin
          if (bus.restart) begin
            fsm         <= IDLE;
            game_over_r <= 1'b0;
            score_r     <= '0;
            div_cnt     <= '0;
            lives_r     <= 3'(LIVES);
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.hit          = hit_r;
  assign bus.game_over    = game_over_r;
  assign bus.flash        = flash_r;
  assign bus.lives        = lives_r;
  assign bus.score_bcd    = score_r;
  assign bus.hi_score_bcd = hi_r;
endmodule

// File: tb/tb_collision_score.sv
// Randomised bench for collision_score against a frame-level model that tracks
// lives, score and high score as plain integers.
module tb_collision_score;
  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_FLASH = 2;
  localparam int M_OVER  = 3;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  int checks = 0;
  int passes = 0;

  int m_mode;
  int m_lives;
  int m_score;
  int m_hi;
  int m_frames;
  int m_flash_left;
  int frame_overlap;
  bit m_hit;

  int hs[5] = '{142, 143, 500, 784, 785};
  int vs[5] = '{33, 34, 300, 516, 517};

  always #5 CLK = ~CLK;

  collision_score_if #(.CIDXW(3), .CORDW(10)) bus ();
  collision_score_if #(.CIDXW(3), .CORDW(10)) bus2 ();

  collision_score #(
    .CIDXW(3), .CORDW(10), .HIT_THRESH(4), .LIVES(3), .FLASH_FRAMES(60), .SCORE_DIV(6)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus.slave)
  );

  // Second instance scores on every frame so the 9999 ceiling is reachable quickly.
  collision_score #(
    .CIDXW(3), .CORDW(10), .HIT_THRESH(4), .LIVES(3), .FLASH_FRAMES(60), .SCORE_DIV(1)
  ) dut2 (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus2.slave)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit in_window(input int h, input int v);
    return (h >= 143) && (h <= 784) && (v >= 34) && (v <= 516);
  endfunction

  function automatic logic [3:0] pick_state();
    int unsigned v;
    if ($urandom_range(0, 9) < 8) return 4'($urandom_range(5, 10));
    v = $urandom_range(0, 9);
    return (v < 5) ? 4'(v) : 4'(v + 6);
  endfunction

  task automatic model_reset();
    m_mode        = M_IDLE;
    m_lives       = 3;
    m_score       = 0;
    m_hi          = 0;
    m_frames      = 0;
    m_flash_left  = 0;
    frame_overlap = 0;
    m_hit         = 1'b0;
  endtask

  // One frame boundary: judge the finished frame, then advance the score divider.
  task automatic model_tick(input bit run);
    int ov;
    ov            = frame_overlap;
    frame_overlap = 0;
    m_hit         = 1'b0;
    if (m_mode != M_OVER) begin
      if (m_mode == M_IDLE) begin
        if (run) m_mode = M_PLAY;
      end else if (m_mode == M_FLASH) begin
        m_flash_left--;
        if (m_flash_left == 0) m_mode = M_PLAY;
      end else if (run && ov >= 4) begin
        m_hit = 1'b1;
        m_lives--;
        if (m_lives == 0) begin
          m_mode = M_OVER;
        end else begin
          m_mode       = M_FLASH;
          m_flash_left = 60;
        end
      end
      if (run) begin
        m_frames++;
        if (m_frames == 6) begin
          m_frames = 0;
          if (m_score < 9999) m_score++;
        end
      end
      if (m_mode == M_OVER && m_score > m_hi) m_hi = m_score;
    end
  endtask

  task automatic checkAllOutputs(input string where);
    checkOutput({where, "_hit"},   16'(bus.hit),       16'(m_hit));
    checkOutput({where, "_lives"}, 16'(bus.lives),     16'(m_lives));
    checkOutput({where, "_flash"}, 16'(bus.flash),     16'(m_mode == M_FLASH));
    checkOutput({where, "_over"},  16'(bus.game_over), 16'(m_mode == M_OVER));
    checkOutput({where, "_score"}, bus.score_bcd,      to_bcd(m_score));
    checkOutput({where, "_hi"},    bus.hi_score_bcd,   to_bcd(m_hi));
  endtask

  // One frame: tick cycle at (0,0), npix coordinate cycles, then a padding cycle that
  // carries the last pixel (and an optional restart).
  task automatic applyStimulus(input logic [3:0] st, input int npix, input int kind,
                               input bit do_restart);
    logic [3:0] prev_p, prev_o, cp, co;
    int         ch, cv;
    bus.state        = st;
    bus.hc           = '0;
    bus.vc           = '0;
    bus.player_pix   = '0;
    bus.obstacle_pix = '0;
    bus.restart      = 1'b0;
    @(posedge CLK); #1;
    model_tick((st >= 4'd5) && (st <= 4'd10));
    checkAllOutputs("tick");
    prev_p = '0;
    prev_o = '0;
    for (int i = 0; i <= npix; i++) begin
      ch = 1; cv = 0; cp = '0; co = '0;
      if (i < npix) begin
        case (kind)
          0: begin ch = 143 + (i % 600); cv = 100; cp = 4'h2; co = 4'h8; end
          1: begin
            ch = hs[$urandom_range(0, 4)];
            cv = vs[$urandom_range(0, 4)];
            cp = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            co = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
          end
          default: begin ch = 200 + i; cv = 200; cp = 4'h5; co = 4'h0; end
        endcase
      end
      bus.hc           = 10'(ch);
      bus.vc           = 10'(cv);
      bus.player_pix   = prev_p;
      bus.obstacle_pix = prev_o;
      bus.restart      = do_restart && (i == npix);
      if (in_window(ch, cv) && cp != 4'h0 && co != 4'h0 && frame_overlap < 255) frame_overlap++;
      prev_p = cp;
      prev_o = co;
      @(posedge CLK); #1;
      if (i == 0) checkOutput("hit_width", 16'(bus.hit), 16'd0);
    end
    bus.restart = 1'b0;
    if (do_restart) begin
      if (m_mode == M_OVER) begin
        m_mode   = M_IDLE;
        m_score  = 0;
        m_frames = 0;
        m_lives  = 3;
      end
      checkOutput("restart_over",  16'(bus.game_over), 16'(m_mode == M_OVER));
      checkOutput("restart_lives", 16'(bus.lives),     16'(m_lives));
      checkOutput("restart_score", bus.score_bcd,      to_bcd(m_score));
    end
  endtask

  initial begin
    int guard;
    int saved;
    logic [3:0] st;
    model_reset();
    bus.state = '0; bus.hc = '0; bus.vc = '0; bus.player_pix = '0; bus.obstacle_pix = '0;
    bus.restart = 1'b0;
    bus2.state = '0; bus2.hc = '0; bus2.vc = '0; bus2.player_pix = '0; bus2.obstacle_pix = '0;
    bus2.restart = 1'b0;

    RESET = 1'b0;
    repeat (5) begin
      bus.state        = 4'($urandom);
      bus.hc           = 10'($urandom);
      bus.vc           = 10'($urandom);
      bus.player_pix   = 4'($urandom);
      bus.obstacle_pix = 4'($urandom);
      bus.restart      = 1'($urandom);
      @(posedge CLK); #1;
    end
    checkAllOutputs("reset");
    bus.state = 4'd5; bus.hc = 10'd1; bus.vc = '0;
    bus.player_pix = '0; bus.obstacle_pix = '0; bus.restart = 1'b0;
    RESET = 1'b1;

    for (int f = 1; f <= 7; f++) begin
      applyStimulus(4'd5, 3, 2, 1'b0);
      if (f == 5) checkOutput("score_tick5", bus.score_bcd, 16'h0000);
      if (f == 6) checkOutput("score_tick6", bus.score_bcd, 16'h0001);
    end

    applyStimulus(4'd5, 3, 0, 1'b0);
    applyStimulus(4'd5, 4, 0, 1'b0);
    checkOutput("lives_3px", 16'(bus.lives), 16'd3);
    applyStimulus(4'd5, 2, 2, 1'b0);
    checkOutput("lives_4px", 16'(bus.lives), 16'd2);
    checkOutput("flash_4px", 16'(bus.flash), 16'd1);

    for (int f = 0; f < 60; f++) applyStimulus(4'd5, 10, 0, 1'b0);
    checkOutput("flash_end",   16'(bus.flash), 16'd0);
    checkOutput("lives_invul", 16'(bus.lives), 16'd2);
    applyStimulus(4'd5, 2, 2, 1'b0);
    checkOutput("lives_post_flash", 16'(bus.lives), 16'd1);

    guard = 0;
    while (m_mode != M_OVER && guard < 400) begin
      applyStimulus(4'd5, 5, 0, 1'b0);
      guard++;
    end
    checkOutput("reach_over", 16'(bus.game_over), 16'd1);
    checkOutput("hi_at_over", bus.hi_score_bcd, to_bcd(m_score));
    repeat (3) applyStimulus(4'd5, 6, 0, 1'b0);
    applyStimulus(4'd5, 0, 2, 1'b1);
    checkOutput("hi_after_restart", bus.hi_score_bcd, to_bcd(m_hi));

    applyStimulus(4'd5, 257, 0, 1'b0);
    applyStimulus(4'd5, 1, 2, 1'b0);
    checkOutput("sat_overlap_lives", 16'(bus.lives), 16'd2);

    saved = m_score;
    for (int f = 0; f < 20; f++) applyStimulus(4'd11, $urandom_range(0, 8), 1, 1'b0);
    checkOutput("pause_score", bus.score_bcd, to_bcd(saved));

    for (int f = 0; f < 300; f++) begin
      st = pick_state();
      applyStimulus(st, $urandom_range(0, 8), $urandom_range(0, 2), ($urandom_range(0, 5) == 0));
    end

    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    model_reset();
    checkAllOutputs("async_reset");
    bus.hc = 10'd1; bus.vc = '0; bus.player_pix = '0; bus.obstacle_pix = '0;
    @(posedge CLK); #1;
    RESET = 1'b1;

    for (int n = 1; n <= 10005; n++) begin
      bus2.hc    = 10'd1;
      bus2.state = 4'd5;
      @(posedge CLK); #1;
      bus2.hc = '0;
      @(posedge CLK); #1;
      if (n == 1 || n == 99 || n == 100 || n == 9998 || n == 9999 || n == 10005) begin
        checkOutput("div1_score", bus2.score_bcd, to_bcd((n < 9999) ? n : 9999));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
